// File: rtl/grant_queue_if.sv
// grant_queue_if: arbiter grant input plus valid/ready consumer handshake for grant_queue
interface grant_queue_if;
  logic [2:0] gnt;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_id;
  modport slave (input gnt, out_ready, output out_valid, out_id);
  modport master (output gnt, out_ready, input out_valid, out_id);
endinterface

// File: rtl/grant_queue.sv
// grant_queue: queues one-hot arbiter grants as requester IDs in a show-ahead FIFO with saturating counters and sticky error flags
module grant_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  grant_queue_if.slave           bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic [CNT_W-1:0]       gnt_cnt0,
  output logic [CNT_W-1:0]       gnt_cnt1,
  output logic [CNT_W-1:0]       gnt_cnt2,
  output logic                   overflow,
  output logic                   onehot_err
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d, valid_q, valid_d, ovf_q, ovf_d, err_q, err_d;
  logic [1:0]       id_q, id_d, gid;
  logic [1:0]       mem_q [DEPTH];
  logic [1:0]       mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic             good, push, pop;
  always_comb begin
    good    = $onehot(bus.gnt);
    gid     = {bus.gnt[2], bus.gnt[1]};
    pop     = valid_q && bus.out_ready;
    push    = good && (!full_q || pop);
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d  = level_d == (AW+1)'(DEPTH);
    valid_d = level_d != '0;
    mem_d   = mem_q;
    if (push) mem_d[wr_q] = gid;
    id_d    = valid_d ? mem_d[rd_d] : id_q;
    ovf_d   = ovf_q || (good && full_q && !pop);
    err_d   = err_q || (bus.gnt != '0 && !good);
    for (int i = 0; i < 3; i++)
      cnt_d[i] = (good && bus.gnt[i] && !(&cnt_q[i])) ? cnt_q[i] + 1'b1 : cnt_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '{default: '0};
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign bus.out_valid = valid_q;
  assign bus.out_id    = id_q;
  assign level         = level_q;
  assign full          = full_q;
  assign gnt_cnt0      = cnt_q[0];
  assign gnt_cnt1      = cnt_q[1];
  assign gnt_cnt2      = cnt_q[2];
  assign overflow      = ovf_q;
  assign onehot_err    = err_q;
endmodule

// File: tb/tb_grant_queue.sv
// tb_grant_queue: directed self-checking bench for grant_queue with DEPTH=4 and 3-bit counters
module tb_grant_queue;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] level;
  logic       full, overflow, onehot_err;
  logic [2:0] c0, c1, c2;
  int         errors = 0;
  int         checks = 0;
  grant_queue_if bus ();
  grant_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .level(level), .full(full),
    .gnt_cnt0(c0), .gnt_cnt1(c1), .gnt_cnt2(c2),
    .overflow(overflow), .onehot_err(onehot_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.gnt = 3'b000;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask
  task automatic fill4();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.gnt = 3'b001;
      step();
    end
    bus.gnt = 3'b000;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.gnt = 3'b100;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", bus.out_id); end
    checks++; if (level !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL reset_level got=%0d/%b exp=0/0", level, full); end
    checks++; if ({c0, c1, c2} !== 9'd0) begin errors++; $display("FAIL reset_cnt got=%0d,%0d,%0d exp=0,0,0", c0, c1, c2); end
    checks++; if ({overflow, onehot_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", overflow, onehot_err); end
  endtask
  task automatic test_single();
    do_reset();
    bus.gnt = 3'b010;
    step();
    bus.gnt = 3'b000;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1) begin errors++; $display("FAIL single_head got=%b/%0d exp=1/1", bus.out_valid, bus.out_id); end
    checks++; if (level !== 3'd1 || c1 !== 3'd1) begin errors++; $display("FAIL single_level_cnt got=%0d/%0d exp=1/1", level, c1); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL single_pop got=%b/%0d exp=0/0", bus.out_valid, level); end
    checks++; if (bus.out_id !== 2'd1) begin errors++; $display("FAIL single_id_hold got=%0d exp=1", bus.out_id); end
    bus.out_ready = 1'b1;
    bus.gnt = 3'b100;
    step();
    bus.gnt = 3'b000;
    checks++; if (level !== 3'd1 || bus.out_id !== 2'd2) begin errors++; $display("FAIL ready_ignored_empty got=%0d/%0d exp=1/2", level, bus.out_id); end
  endtask
  task automatic test_ordering();
    logic [2:0] seq [4];
    logic [1:0] ids [4];
    seq = '{3'b001, 3'b100, 3'b010, 3'b001};
    ids = '{2'd0, 2'd2, 2'd1, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.gnt = seq[i];
      step();
    end
    bus.gnt = 3'b000;
    checks++; if (level !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL order_full got=%0d/%b exp=4/1", level, full); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== ids[i]) begin errors++; $display("FAIL order_id%0d got=%b/%0d exp=1/%0d", i, bus.out_valid, bus.out_id, ids[i]); end
      step();
    end
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL order_drained got=%b/%0d/%b exp=0/0/0", bus.out_valid, level, full); end
  endtask
  task automatic test_overflow();
    do_reset();
    fill4();
    bus.gnt = 3'b100;
    step();
    bus.gnt = 3'b000;
    checks++; if (overflow !== 1'b1 || level !== 3'd4) begin errors++; $display("FAIL ovf_drop got=%b/%0d exp=1/4", overflow, level); end
    checks++; if (c2 !== 3'd1 || c0 !== 3'd4) begin errors++; $display("FAIL ovf_cnt got=%0d/%0d exp=1/4", c2, c0); end
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    do_reset();
    fill4();
    bus.gnt = 3'b100;
    bus.out_ready = 1'b1;
    step();
    bus.gnt = 3'b000;
    checks++; if (overflow !== 1'b0 || level !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL full_pushpop got=%b/%0d/%b exp=0/4/1", overflow, level, full); end
    checks++; if (c2 !== 3'd1 || bus.out_id !== 2'd0) begin errors++; $display("FAIL full_pushpop_cnt got=%0d/%0d exp=1/0", c2, bus.out_id); end
    for (int i = 0; i < 3; i++) step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd2 || level !== 3'd1) begin errors++; $display("FAIL full_pushpop_tail got=%b/%0d/%0d exp=1/2/1", bus.out_valid, bus.out_id, level); end
    step();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL full_pushpop_empty got=%b/%0d exp=0/0", bus.out_valid, level); end
  endtask
  task automatic test_malformed();
    do_reset();
    bus.gnt = 3'b001;
    step();
    bus.gnt = 3'b011;
    step();
    checks++; if (onehot_err !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL malformed_flag got=%b/%0d exp=1/1", onehot_err, level); end
    checks++; if (c0 !== 3'd1 || c1 !== 3'd0 || c2 !== 3'd0) begin errors++; $display("FAIL malformed_cnt got=%0d,%0d,%0d exp=1,0,0", c0, c1, c2); end
    bus.gnt = 3'b111;
    step();
    checks++; if (level !== 3'd1 || c2 !== 3'd0) begin errors++; $display("FAIL malformed_111 got=%0d/%0d exp=1/0", level, c2); end
    bus.gnt = 3'b001;
    step();
    bus.gnt = 3'b000;
    checks++; if (level !== 3'd2 || c0 !== 3'd2 || onehot_err !== 1'b1) begin errors++; $display("FAIL malformed_next got=%0d/%0d/%b exp=2/2/1", level, c0, onehot_err); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_id !== 2'd0 || level !== 3'd1) begin errors++; $display("FAIL malformed_pop got=%0d/%0d exp=0/1", bus.out_id, level); end
    bus.out_ready = 1'b0;
  endtask
  task automatic test_saturation();
    do_reset();
    bus.out_ready = 1'b1;
    bus.gnt = 3'b001;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (c0 !== ((i < 7) ? 3'(i + 1) : 3'd7)) begin errors++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, c0, (i < 7) ? i + 1 : 7); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || level !== 3'd1) begin errors++; $display("FAIL sat_stream%0d got=%b/%0d/%0d exp=1/0/1", i, bus.out_valid, bus.out_id, level); end
    end
    bus.gnt = 3'b000;
    bus.out_ready = 1'b0;
  endtask
  task automatic test_reset_mid();
    do_reset();
    fill4();
    bus.gnt = 3'b010;
    step();
    bus.gnt = 3'b000;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++; if (level !== 3'd3 || overflow !== 1'b1) begin errors++; $display("FAIL mid_setup got=%0d/%b exp=3/1", level, overflow); end
    rst = 1'b1;
    bus.gnt = 3'b100;
    step();
    rst = 1'b0;
    bus.gnt = 3'b000;
    checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0 || full !== 1'b0 || bus.out_id !== 2'd0) begin errors++; $display("FAIL mid_reset_fifo got=%b/%0d/%b/%0d exp=0/0/0/0", bus.out_valid, level, full, bus.out_id); end
    checks++; if ({c0, c1, c2} !== 9'd0 || overflow !== 1'b0 || onehot_err !== 1'b0) begin errors++; $display("FAIL mid_reset_stats got=%0d,%0d,%0d/%b/%b exp=0,0,0/0/0", c0, c1, c2, overflow, onehot_err); end
    bus.gnt = 3'b010;
    step();
    bus.gnt = 3'b000;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1 || level !== 3'd1 || c1 !== 3'd1 || c2 !== 3'd0) begin errors++; $display("FAIL mid_after got=%b/%0d/%0d/%0d/%0d exp=1/1/1/1/0", bus.out_valid, bus.out_id, level, c1, c2); end
  endtask
  initial begin
    rst = 1'b1;
    bus.gnt = 3'b000;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_ordering();
    test_overflow();
    test_malformed();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
